// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path: index geometry, queued update record, scheduler states.
package bp_pkg;

  localparam int BP_ENTRIES = 8;
  localparam int BP_IDXW    = $clog2(BP_ENTRIES);

  typedef struct packed {
    logic [BP_IDXW-1:0] idx;
    logic               taken;
    logic [15:0]        target;
    logic               mispred;
  } bp_upd_t;

  typedef enum logic {
    CLEAR,
    RUN
  } bp_sched_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: DEPTH-entry FIFO of bp_upd_t, head readable the cycle after a push (no bypass).
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged by assertion.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  bp_upd_t                  push_dat,
  input  logic                     pop,
  output bp_upd_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  bp_upd_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same edge, so push-at-full is legal only alongside a pop.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= push_dat;
  end

  overflow_push: assert property (@(posedge clk) disable iff (rst || clear)
                                  !(push && full && !pop));

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues resolved-branch predictor updates and issues them on idle predictor-port cycles; sweeps-clears after reset/flush.
// Issue is same-cycle from the FIFO head; fetch_hold stalls fetch when full. BP_SCHED_PERF_EN adds perf counters.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  input  logic [3:0]         res_pc,
  input  logic               res_taken,
  input  logic [15:0]        res_target,
  input  logic               res_mispred,
  input  logic               fetch_rd,
  input  logic               flush_req,
  output logic               upd_en,
  output logic [BP_IDXW-1:0] upd_idx,
  output logic               upd_taken,
  output logic [15:0]        upd_target,
  output logic               upd_bht,
  output logic               clr,
  output logic               fetch_hold,
  output logic               busy
`ifdef BP_SCHED_PERF_EN
  ,
  output logic [15:0]        perf_issued,
  output logic [15:0]        perf_hold
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]      HOLD_LOW  = CW'(DEPTH - 1);
  localparam logic [BP_IDXW-1:0] LAST_IDX  = BP_IDXW'(ENTRIES - 1);

  bp_sched_state_e     state;
  logic [BP_IDXW-1:0]  sweep_idx;
  bp_upd_t             push_dat;
  bp_upd_t             head;
  logic [CW-1:0]       count;
  logic [CW-1:0]       cnt_nxt;
  logic                full;
  logic                empty;
  logic                in_run;
  logic                push;
  logic                push_acc;
  logic                issue;
  logic                fifo_clear;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = res_pc[0];

  assign in_run     = (state == RUN);
  assign push       = in_run & res_valid;
  assign fifo_clear = in_run & flush_req;
  assign issue      = ~rst & in_run & ~empty & (~fetch_rd | fetch_hold);
  assign push_acc   = push & (~full | issue);
  assign cnt_nxt    = count + CW'(push_acc) - CW'(issue);

  assign push_dat = '{idx: res_pc[3:1], taken: res_taken, target: res_target, mispred: res_mispred};

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (fifo_clear),
    .push     (push),
    .push_dat (push_dat),
    .pop      (issue),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Clear writes own the port outright during CLEAR; otherwise only a real issue drives it.
  always_comb begin
    upd_en     = 1'b0;
    clr        = 1'b0;
    upd_idx    = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_bht    = 1'b0;
    if (!rst) begin
      if (state == CLEAR) begin
        upd_en  = 1'b1;
        clr     = 1'b1;
        upd_idx = sweep_idx;
      end else if (issue) begin
        upd_en     = 1'b1;
        upd_idx    = head.idx;
        upd_taken  = head.taken;
        upd_target = head.target;
        upd_bht    = head.mispred;
      end
    end
  end

  assign busy = rst | ~in_run | (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      sweep_idx  <= '0;
      fetch_hold <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          fetch_hold <= 1'b1;
          if (flush_req) begin
            sweep_idx <= '0;
          end else if (sweep_idx == LAST_IDX) begin
            state      <= RUN;
            sweep_idx  <= '0;
            fetch_hold <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        RUN: begin
          if (flush_req) begin
            state      <= CLEAR;
            sweep_idx  <= '0;
            fetch_hold <= 1'b1;
          end else if (cnt_nxt == FULL_CNT) begin
            fetch_hold <= 1'b1;
          end else if (cnt_nxt < HOLD_LOW) begin
            fetch_hold <= 1'b0;
          end
        end
        default: begin
          state      <= CLEAR;
          sweep_idx  <= '0;
          fetch_hold <= 1'b1;
        end
      endcase
    end
  end

`ifdef BP_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_hold   <= '0;
    end else begin
      if (upd_en && !clr && perf_issued != 16'hFFFF) perf_issued <= perf_issued + 1'b1;
      if (fetch_hold && in_run && perf_hold != 16'hFFFF) perf_hold <= perf_hold + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler: reset sweep, issue, contention, full/hold, push+pop at full, flush.
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [3:0]  res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic        res_mispred;
  logic        fetch_rd;
  logic        flush_req;
  logic        upd_en;
  logic [2:0]  upd_idx;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_bht;
  logic        clr;
  logic        fetch_hold;
  logic        busy;
`ifdef BP_SCHED_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_hold;
`endif

  int checks   = 0;
  int failures = 0;

  // Observed write bus: {en, clr, taken, bht, idx, target}
  wire [22:0] ub = {upd_en, clr, upd_taken, upd_bht, upd_idx, upd_target};

  always #5 clk = ~clk;

  bp_update_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .res_mispred (res_mispred),
    .fetch_rd    (fetch_rd),
    .flush_req   (flush_req),
    .upd_en      (upd_en),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_bht     (upd_bht),
    .clr         (clr),
    .fetch_hold  (fetch_hold),
    .busy        (busy)
`ifdef BP_SCHED_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_hold   (perf_hold)
`endif
  );

  function automatic logic [22:0] wr(input logic [2:0] idx, input logic t, input logic b, input logic [15:0] tg);
    return {1'b1, 1'b0, t, b, idx, tg};
  endfunction

  function automatic logic [22:0] sw(input logic [2:0] idx);
    return {1'b1, 1'b1, 1'b0, 1'b0, idx, 16'h0000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] pc, input logic t, input logic [15:0] tg, input logic m);
    res_valid   = v;
    res_pc      = pc;
    res_taken   = t;
    res_target  = tg;
    res_mispred = m;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_rd = 1'b0; flush_req = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (ub !== 23'h0) begin failures++; $display("FAIL rst_bus got=%h exp=%h", ub, 23'h0); end
    checks++;
    if ({fetch_hold, busy} !== 2'b11) begin failures++; $display("FAIL rst_hold_busy got=%b exp=11", {fetch_hold, busy}); end
    checks++;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (ub !== sw(3'(i))) begin failures++; $display("FAIL sweep_%0d got=%h exp=%h", i, ub, sw(3'(i))); end
      checks++;
      if ({fetch_hold, busy} !== 2'b11) begin failures++; $display("FAIL sweep_hold_%0d got=%b exp=11", i, {fetch_hold, busy}); end
      checks++;
      tick; #1;
    end
    if ({ub, fetch_hold, busy} !== 25'h0) begin failures++; $display("FAIL post_sweep got=%h exp=0", {ub, fetch_hold, busy}); end
    checks++;
  endtask

  task automatic test_idle_port;
    fetch_rd = 1'b0;
    drive(1'b1, 4'hA, 1'b1, 16'h1234, 1'b0);
    #1;
    if (ub !== 23'h0) begin failures++; $display("FAIL idle_no_bypass got=%h exp=0", ub); end
    checks++;
    tick;
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    #1;
    if (ub !== wr(3'd5, 1'b1, 1'b0, 16'h1234)) begin failures++; $display("FAIL idle_write got=%h exp=%h", ub, wr(3'd5, 1'b1, 1'b0, 16'h1234)); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL idle_busy got=%b exp=1", busy); end
    checks++;
    tick; #1;
    if ({ub, busy} !== 24'h0) begin failures++; $display("FAIL idle_after got=%h exp=0", {ub, busy}); end
    checks++;
  endtask

  task automatic test_contention;
    fetch_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(2 * (i + 1)), (i % 2 == 1), 16'(16'h1111 * (i + 1)), (i % 2 == 0));
      #1;
      if (ub !== 23'h0) begin failures++; $display("FAIL cont_blocked_%0d got=%h exp=0", i, ub); end
      checks++;
      tick;
    end
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    #1;
    if ({ub, fetch_hold} !== 24'h0) begin failures++; $display("FAIL cont_wait got=%h exp=0", {ub, fetch_hold}); end
    checks++;
    fetch_rd = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (ub !== wr(3'(i + 1), (i % 2 == 1), (i % 2 == 0), 16'(16'h1111 * (i + 1)))) begin
        failures++;
        $display("FAIL cont_order_%0d got=%h exp=%h", i, ub, wr(3'(i + 1), (i % 2 == 1), (i % 2 == 0), 16'(16'h1111 * (i + 1))));
      end
      checks++;
      tick; #1;
    end
    if ({ub, busy} !== 24'h0) begin failures++; $display("FAIL cont_drained got=%h exp=0", {ub, busy}); end
    checks++;
  endtask

  task automatic test_full;
    fetch_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(8 + 2 * i), 1'b1, 16'(16'h4000 + i), 1'b0);
      #1;
      if (fetch_hold !== 1'b0) begin failures++; $display("FAIL full_hold_pre_%0d got=%b exp=0", i, fetch_hold); end
      checks++;
      tick;
    end
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    #1;
    if (fetch_hold !== 1'b1) begin failures++; $display("FAIL full_hold_set got=%b exp=1", fetch_hold); end
    checks++;
    if (ub !== wr(3'd4, 1'b1, 1'b0, 16'h4000)) begin failures++; $display("FAIL full_issue0 got=%h exp=%h", ub, wr(3'd4, 1'b1, 1'b0, 16'h4000)); end
    checks++;
    tick; #1;
    if ({fetch_hold, ub} !== {1'b1, wr(3'd5, 1'b1, 1'b0, 16'h4001)}) begin failures++; $display("FAIL full_issue1 got=%h exp=%h", {fetch_hold, ub}, {1'b1, wr(3'd5, 1'b1, 1'b0, 16'h4001)}); end
    checks++;
    tick; #1;
    if ({fetch_hold, ub} !== 24'h0) begin failures++; $display("FAIL full_hold_release got=%h exp=0", {fetch_hold, ub}); end
    checks++;
    fetch_rd = 1'b0;
    #1;
    for (int i = 2; i < 4; i++) begin
      if (ub !== wr(3'(4 + i), 1'b1, 1'b0, 16'(16'h4000 + i))) begin failures++; $display("FAIL full_drain_%0d got=%h exp=%h", i, ub, wr(3'(4 + i), 1'b1, 1'b0, 16'(16'h4000 + i))); end
      checks++;
      tick; #1;
    end
    if ({ub, busy} !== 24'h0) begin failures++; $display("FAIL full_drained got=%h exp=0", {ub, busy}); end
    checks++;
  endtask

  task automatic test_back_to_back;
`ifdef BP_SCHED_PERF_EN
    logic [15:0] p0;
`endif
    fetch_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(2 * i), 1'b0, 16'(16'hA000 + i), 1'b1);
      tick;
    end
`ifdef BP_SCHED_PERF_EN
    p0 = perf_issued;
`endif
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 4'(8 + 2 * j), 1'b0, 16'(16'hA004 + j), 1'b1);
      #1;
      if (ub !== wr(3'(j), 1'b0, 1'b1, 16'(16'hA000 + j))) begin failures++; $display("FAIL b2b_issue_%0d got=%h exp=%h", j, ub, wr(3'(j), 1'b0, 1'b1, 16'(16'hA000 + j))); end
      checks++;
      tick; #1;
      if ({fetch_hold, busy} !== 2'b11) begin failures++; $display("FAIL b2b_hold_%0d got=%b exp=11", j, {fetch_hold, busy}); end
      checks++;
`ifdef BP_SCHED_PERF_EN
      if (perf_issued !== 16'(p0 + j + 1)) begin failures++; $display("FAIL b2b_perf_%0d got=%h exp=%h", j, perf_issued, 16'(p0 + j + 1)); end
      checks++;
`endif
    end
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    #1;
    for (int i = 2; i < 4; i++) begin
      if (ub !== wr(3'(i), 1'b0, 1'b1, 16'(16'hA000 + i))) begin failures++; $display("FAIL b2b_held_%0d got=%h exp=%h", i, ub, wr(3'(i), 1'b0, 1'b1, 16'(16'hA000 + i))); end
      checks++;
      tick; #1;
    end
    if ({fetch_hold, ub} !== 24'h0) begin failures++; $display("FAIL b2b_release got=%h exp=0", {fetch_hold, ub}); end
    checks++;
    fetch_rd = 1'b0;
    #1;
    for (int i = 4; i < 6; i++) begin
      if (ub !== wr(3'(i), 1'b0, 1'b1, 16'(16'hA000 + i))) begin failures++; $display("FAIL b2b_tail_%0d got=%h exp=%h", i, ub, wr(3'(i), 1'b0, 1'b1, 16'(16'hA000 + i))); end
      checks++;
      tick; #1;
    end
    if ({ub, busy} !== 24'h0) begin failures++; $display("FAIL b2b_drained got=%h exp=0", {ub, busy}); end
    checks++;
  endtask

  task automatic test_flush;
    fetch_rd = 1'b1;
    drive(1'b1, 4'h2, 1'b1, 16'h5555, 1'b0);
    tick;
    drive(1'b1, 4'h4, 1'b1, 16'h6666, 1'b0);
    tick;
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    flush_req = 1'b1;
    #1;
    if ({ub, busy} !== 24'h1) begin failures++; $display("FAIL flush_cycle got=%h exp=1", {ub, busy}); end
    checks++;
    tick;
    flush_req = 1'b0;
    fetch_rd  = 1'b0;
    drive(1'b1, 4'h6, 1'b1, 16'hBEEF, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      if ({fetch_hold, ub} !== {1'b1, sw(3'(i))}) begin failures++; $display("FAIL flush_sweep_%0d got=%h exp=%h", i, {fetch_hold, ub}, {1'b1, sw(3'(i))}); end
      checks++;
      if (i == 3) flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
      #1;
    end
    for (int i = 0; i < 8; i++) begin
      if ({fetch_hold, ub} !== {1'b1, sw(3'(i))}) begin failures++; $display("FAIL restart_sweep_%0d got=%h exp=%h", i, {fetch_hold, ub}, {1'b1, sw(3'(i))}); end
      checks++;
      tick; #1;
    end
    drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    #1;
    if ({ub, fetch_hold, busy} !== 25'h0) begin failures++; $display("FAIL flush_done got=%h exp=0", {ub, fetch_hold, busy}); end
    checks++;
    tick; #1;
    if ({ub, busy} !== 24'h0) begin failures++; $display("FAIL flush_no_stale got=%h exp=0", {ub, busy}); end
    checks++;
  endtask

  initial begin
    test_reset;
    test_idle_port;
    test_contention;
    test_full;
    test_back_to_back;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
